// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU front end.
//   PC_W / INSTR_W   - program counter and instruction widths
//   OP_*             - 2-bit opcode field values (instr[7:6])
//   fetch_state_e    - fetch stage state machine encoding
package cpu_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_J   = 2'b11;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/jump_target.sv
// jump_target: combinational PC-relative target computation.
//   target = pc + 1 + sign_extend(imm6), wrapping modulo 2^PC_W.
// Ports:
//   pc_i     - current program counter
//   imm_i    - 6-bit signed displacement
//   target_o - resolved target address
module jump_target #(
    parameter int unsigned PC_W = cpu_pkg::PC_W
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [5:0]      imm_i,
    output logic [PC_W-1:0] target_o
);

    always_comb begin
        target_o = pc_i + PC_W'(1) + {{(PC_W-6){imm_i[5]}}, imm_i};
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the instruction memory.
// Owns the PC, samples the combinational memory read data and hands
// non-jump instructions to decode through a valid/ready register.
// Jumps (opcode OP_J) are resolved here and never forwarded.
// Optional feature macro: FETCH_STATS_EN enables the saturating
// fetch_count / jump_count counters; otherwise both ports read 0.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-low reset
//   pc                - fetch address to instruction memory
//   instr_code        - memory read data for pc (same cycle)
//   id_instr, id_pc   - instruction and its address held for decode
//   id_valid/id_ready - decode handshake
//   halted            - fetch has stopped (PC left the program)
//   fetch_count       - non-jump instructions delivered (saturating)
//   jump_count        - jumps folded (saturating)
module fetch_unit #(
    parameter int unsigned PC_W     = cpu_pkg::PC_W,
    parameter int unsigned INSTR_W  = cpu_pkg::INSTR_W,
    parameter int unsigned PROG_LEN = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr_code,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic               halted,
    output logic [7:0]         fetch_count,
    output logic [7:0]         jump_count
);

    import cpu_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    id_pc_q, id_pc_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic               id_valid_q, id_valid_d;

    logic               advance;
    logic               out_of_prog;
    logic               is_jump;
    logic               fetch_evt;
    logic               jump_evt;
    logic [PC_W-1:0]    jump_pc;

    jump_target #(
        .PC_W (PC_W)
    ) u_jump_target (
        .pc_i     (pc_q),
        .imm_i    (instr_code[5:0]),
        .target_o (jump_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        id_valid_d  = id_valid_q;
        fetch_evt   = 1'b0;
        jump_evt    = 1'b0;

        advance     = (state_q == RUN) && (!id_valid_q || id_ready);
        out_of_prog = (pc_q >= PC_W'(PROG_LEN));
        is_jump     = (instr_code[INSTR_W-1 -: 2] == OP_J);

        case (state_q)
            // Guard cycle while the instruction memory comes out of reset.
            BOOT: state_d = RUN;
            RUN: begin
                if (advance) begin
                    if (out_of_prog) begin
                        state_d    = HALT;
                        id_valid_d = 1'b0;
                    end else if (is_jump) begin
                        // Jump folded: the slot becomes a bubble.
                        pc_d       = jump_pc;
                        id_valid_d = 1'b0;
                        jump_evt   = 1'b1;
                    end else begin
                        id_instr_d = instr_code;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_q + PC_W'(1);
                        fetch_evt  = 1'b1;
                    end
                end
            end
            HALT: begin
                if (id_ready) begin
                    id_valid_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= PC_W'(RESET_PC);
            id_pc_q    <= '0;
            id_instr_q <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign pc       = pc_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_valid = id_valid_q;
    assign halted   = (state_q == HALT);

`ifdef FETCH_STATS_EN
    logic [7:0] fetch_cnt_q;
    logic [7:0] jump_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            jump_cnt_q  <= '0;
        end else begin
            if (fetch_evt && (fetch_cnt_q != 8'hFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 8'd1;
            end
            if (jump_evt && (jump_cnt_q != 8'hFF)) begin
                jump_cnt_q <= jump_cnt_q + 8'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign jump_count  = jump_cnt_q;
`else
    logic unused_evt;
    assign unused_evt  = fetch_evt ^ jump_evt;
    assign fetch_count = '0;
    assign jump_count  = '0;
`endif

endmodule
